pj_fluxo_dados_n: RTL and testbench
===================================

# pj_fluxo_dados_n

Parametrised MindFocus round engine: plays one round of the button-sequence game against a synchronous sequence ROM, with an integrated round FSM and per-play hit/error/timeout accounting. It generalises the fixed 4-button/16-entry game datapath to N buttons and arbitrary depth. Sits between the debounced button inputs and the top-level display/score logic.

## Interface

- N_BOTOES, 4, number of buttons; also the ROM word width (one-hot expected button)
- DEPTH, 16, plays per round = ROM entries (≥2)
- MEM_FILE, "mem_jogo.hex", ROM init file ($readmemh)
- TIMEOUT_CICLOS, 5000, max cycles waiting for a press (used only with PJ_TIMEOUT_EN)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- iniciar  in  1  start-round request, level-sampled
- botoes  in  N_BOTOES  debounced button levels
- acertos  out  $clog2(DEPTH+1)  correct plays this round
- erros  out  $clog2(DEPTH+1)  wrong or timed-out plays this round
- jogada_feita  out  1  one-cycle pulse, press accepted
- acertou / errou  out  1  one-cycle pulses, result of the current play
- timeout  out  1  one-cycle pulse, play expired
- pronto  out  1  round finished, level
- db_estado  out  3  FSM state code
- db_endereco  out  $clog2(DEPTH)  current ROM address
- db_jogada / db_memoria  out  N_BOTOES  registered press / ROM word

## Operation

- States: INICIAL, PREPARA, ESPERA, COMPARA, SOLTA, PROXIMA, FIM.
- INICIAL: iniciar=1 → PREPARA. PREPARA: clear acertos, erros, address, jogada register → ESPERA.
- ESPERA: press = rising edge of |botoes (previous sample 0, current ≠0). On press: jogada_feita=1, register botoes → COMPARA.
- COMPARA: equal (register == ROM word) → acertou, acertos+1; else errou, erros+1. → SOLTA.
- SOLTA: wait |botoes==0 → PROXIMA. Presses here ignored.
- PROXIMA: address==DEPTH-1 → FIM; else address+1 → ESPERA.
- FIM: pronto=1; iniciar=1 → PREPARA (new round). iniciar ignored in every other state.
- Multi-button press: registered as-is; never equals a one-hot ROM word → error.
- Button held from previous round/play: no edge, no press until released and re-pressed.
- acertos+erros ≤ DEPTH by construction; counters never wrap.

## Timing

- Reset: state INICIAL, all outputs 0, counters/address/registers 0.
- Reset asserted mid-round: immediate return to INICIAL; round discarded.
- Press edge in ESPERA cycle t → jogada_feita at t; acertou/errou at t+1; counter updated visible at t+2.
- ROM: 1-cycle synchronous read. Address updated at end of PROXIMA (cycle p); ROM word valid from p+2; earliest COMPARA is p+2, so no stall needed.
- Minimum play: ESPERA, COMPARA, SOLTA, PROXIMA = 4 cycles.
- pronto asserted from the first FIM cycle until leaving FIM.

## Configuration

- PJ_TIMEOUT_EN defined: cycle counter cleared on ESPERA entry; after TIMEOUT_CICLOS cycles in ESPERA without press → timeout=1, errou=1, erros+1, → PROXIMA (SOLTA skipped). Press and expiry in the same cycle: press wins, no timeout.
- Undefined: no counter; ESPERA waits indefinitely; timeout tied 0.

## Structure

- Package pj_pkg: state enum with fixed 3-bit codes (INICIAL=0 … FIM=6), default parameter constants.
- Sub-module: edge_detector (clock, reset, sinal, pulso) for the press edge; ROM, counters, register, comparator inline.

## Test plan

- N_BOTOES=4, DEPTH=4, ROM {1,2,4,8}; presses 1,2,4,8 → four acertou pulses, acertos=4, erros=0, pronto=1.
- Same ROM; presses 1,4,4,8 → errou on play 2, final acertos=3, erros=1.
- Press 4'b0011 on play 1 → errou, erros=1; held buttons never re-trigger until released.
- PJ_TIMEOUT_EN, TIMEOUT_CICLOS=10; no press on play 1 → timeout+errou at 10th ESPERA cycle, address advances to 1.
- reset pulse during SOLTA of play 3 → all outputs 0, state INICIAL; iniciar restarts at address 0.
- iniciar held in ESPERA → no effect; iniciar in FIM → counters cleared, new round.

Source files
------------

// File: rtl/pj_pkg.sv
// Shared definitions for the MindFocus round engine: FSM state codes and
// default parameter values.
package pj_pkg;

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    PREPARA = 3'd1,
    ESPERA  = 3'd2,
    COMPARA = 3'd3,
    SOLTA   = 3'd4,
    PROXIMA = 3'd5,
    FIM     = 3'd6
  } estado_t;

  localparam int PJ_N_BOTOES_DEF = 4;
  localparam int PJ_DEPTH_DEF    = 16;
  localparam int PJ_TIMEOUT_DEF  = 5000;

endpackage

// File: rtl/pj_fluxo_dados_n_edge_detector.sv
// Rising-edge detector: pulso is high for the cycle in which sinal goes 0 -> 1.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic sinal_q;

  // Previous sample of the input level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sinal_q <= 1'b0;
    else       sinal_q <= sinal;
  end

  assign pulso = sinal & ~sinal_q;

endmodule

// File: rtl/pj_fluxo_dados_n.sv
// MindFocus round engine: plays one round of N-button sequence game against a
// synchronous ROM, counting hits and errors per play.
// Optional feature: define PJ_TIMEOUT_EN to expire a play after TIMEOUT_CICLOS
// cycles without a press.
// ROM contents: built-in rotating one-hot sequence.
module pj_fluxo_dados_n
  import pj_pkg::*;
#(
  parameter int    N_BOTOES       = PJ_N_BOTOES_DEF,
  parameter int    DEPTH          = PJ_DEPTH_DEF,
  parameter string MEM_FILE       = "mem_jogo.hex",
  parameter int    TIMEOUT_CICLOS = PJ_TIMEOUT_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       iniciar,
  input  logic [N_BOTOES-1:0]        botoes,
  output logic [$clog2(DEPTH+1)-1:0] acertos,
  output logic [$clog2(DEPTH+1)-1:0] erros,
  output logic                       jogada_feita,
  output logic                       acertou,
  output logic                       errou,
  output logic                       timeout,
  output logic                       pronto,
  output logic [2:0]                 db_estado,
  output logic [$clog2(DEPTH)-1:0]   db_endereco,
  output logic [N_BOTOES-1:0]        db_jogada,
  output logic [N_BOTOES-1:0]        db_memoria
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  estado_t             estado_q, estado_d;
  logic [AW-1:0]       endereco_q, endereco_d;
  logic [CW-1:0]       acertos_q, acertos_d;
  logic [CW-1:0]       erros_q, erros_d;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic [N_BOTOES-1:0] memoria_q;
  logic                pressionado;
  logic                pulso;
  logic                expirou;

  assign pressionado = |botoes;

  edge_detector u_borda (
    .clock (clock),
    .reset (reset),
    .sinal (pressionado),
    .pulso (pulso)
  );

`ifdef PJ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS+1);
  logic [TW-1:0] tempo_q, tempo_d;

  // Cycles spent in ESPERA; held at zero in every other state.
  always_comb tempo_d = (estado_q == ESPERA) ? tempo_q + 1'b1 : '0;

  // Timeout cycle counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) tempo_q <= '0;
    else       tempo_q <= tempo_d;
  end

  assign expirou = (estado_q == ESPERA) && (tempo_q == TW'(TIMEOUT_CICLOS-1));
`else
  assign expirou = 1'b0;
`endif

  // Synchronous ROM read of the built-in sequence 1,2,4,... wrapping on N_BOTOES.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) memoria_q <= '0;
    else       memoria_q <= N_BOTOES'(1) << (int'(endereco_q) % N_BOTOES);
  end

  // Round FSM next state, datapath updates and one-cycle result pulses.
  always_comb begin
    estado_d     = estado_q;
    endereco_d   = endereco_q;
    acertos_d    = acertos_q;
    erros_d      = erros_q;
    jogada_d     = jogada_q;
    jogada_feita = 1'b0;
    acertou      = 1'b0;
    errou        = 1'b0;
    timeout      = 1'b0;
    pronto       = 1'b0;
    case (estado_q)
      INICIAL: if (iniciar) estado_d = PREPARA;
      PREPARA: begin
        endereco_d = '0;
        acertos_d  = '0;
        erros_d    = '0;
        jogada_d   = '0;
        estado_d   = ESPERA;
      end
      ESPERA: begin
        // A press in the expiry cycle takes priority over the timeout.
        if (pulso) begin
          jogada_feita = 1'b1;
          jogada_d     = botoes;
          estado_d     = COMPARA;
        end else if (expirou) begin
          timeout  = 1'b1;
          errou    = 1'b1;
          erros_d  = erros_q + 1'b1;
          estado_d = PROXIMA;
        end
      end
      COMPARA: begin
        if (jogada_q == memoria_q) begin
          acertou   = 1'b1;
          acertos_d = acertos_q + 1'b1;
        end else begin
          errou   = 1'b1;
          erros_d = erros_q + 1'b1;
        end
        estado_d = SOLTA;
      end
      SOLTA: if (!pressionado) estado_d = PROXIMA;
      PROXIMA: begin
        if (endereco_q == AW'(DEPTH-1)) begin
          estado_d = FIM;
        end else begin
          endereco_d = endereco_q + 1'b1;
          estado_d   = ESPERA;
        end
      end
      FIM: begin
        pronto = 1'b1;
        if (iniciar) estado_d = PREPARA;
      end
      default: estado_d = INICIAL;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= INICIAL;
      endereco_q <= '0;
      acertos_q  <= '0;
      erros_q    <= '0;
      jogada_q   <= '0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      acertos_q  <= acertos_d;
      erros_q    <= erros_d;
      jogada_q   <= jogada_d;
    end
  end

  assign acertos     = acertos_q;
  assign erros       = erros_q;
  assign db_estado   = estado_q;
  assign db_endereco = endereco_q;
  assign db_jogada   = jogada_q;
  assign db_memoria  = memoria_q;

endmodule

// File: tb/tb_pj_fluxo_dados_n.sv
// Scoreboard bench for pj_fluxo_dados_n with N_BOTOES=4, DEPTH=4 and the
// built-in ROM sequence {1,2,4,8}. Optional PJ_TIMEOUT_EN with 10 cycles.
module tb_pj_fluxo_dados_n;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [3:0] botoes = 4'd0;
  logic [2:0] acertos, erros;
  logic       jogada_feita, acertou, errou, timeout, pronto;
  logic [2:0] db_estado;
  logic [1:0] db_endereco;
  logic [3:0] db_jogada, db_memoria;

  pj_fluxo_dados_n #(
    .N_BOTOES       (4),
    .DEPTH          (4),
    .MEM_FILE       (""),
    .TIMEOUT_CICLOS (10)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .botoes       (botoes),
    .acertos      (acertos),
    .erros        (erros),
    .jogada_feita (jogada_feita),
    .acertou      (acertou),
    .errou        (errou),
    .timeout      (timeout),
    .pronto       (pronto),
    .db_estado    (db_estado),
    .db_endereco  (db_endereco),
    .db_jogada    (db_jogada),
    .db_memoria   (db_memoria)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       ac;
    logic       er;
    logic       to;
    logic       chk_j;
    logic [3:0] jog;
    logic [1:0] addr;
    logic [2:0] n_ac;
    logic [2:0] n_er;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_feita = 0;
  int   exp_ac = 0;
  int   exp_er = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Monitor: pops one expectation per result pulse; counters checked a cycle later.
  exp_t pend;
  bit   pend_v = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (pend_v) begin
      chk("acertos_after_play", int'(acertos), int'(pend.n_ac));
      chk("erros_after_play", int'(erros), int'(pend.n_er));
      pend_v = 1'b0;
    end
    if (jogada_feita) n_feita++;
    if (acertou || errou || timeout) begin
      if (sb.size() == 0) begin
        chk("unexpected_result_pulse", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("acertou", int'(acertou), int'(e.ac));
        chk("errou", int'(errou), int'(e.er));
        chk("timeout", int'(timeout), int'(e.to));
        chk("play_address", int'(db_endereco), int'(e.addr));
        if (e.chk_j) chk("db_jogada", int'(db_jogada), int'(e.jog));
        pend   = e;
        pend_v = 1'b1;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    int k = 0;
    while (db_estado !== s && k < 200) begin
      tick();
      k++;
    end
    if (db_estado !== s) chk(nm, int'(db_estado), int'(s));
  endtask

  task automatic start_round();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    exp_ac  = 0;
    exp_er  = 0;
  endtask

  task automatic play(input logic [3:0] v, input logic hit, input logic [1:0] addr);
    exp_t e;
    wait_state(3'd2, "wait_espera");
    if (hit) exp_ac++; else exp_er++;
    e = '{ac: hit, er: !hit, to: 1'b0, chk_j: 1'b1, jog: v, addr: addr,
          n_ac: 3'(exp_ac), n_er: 3'(exp_er)};
    sb.push_back(e);
    botoes = v;
    tick(3);
    botoes = 4'd0;
    tick();
  endtask

  task automatic end_round(input string nm, input int ac, input int er);
    wait_state(3'd6, {nm, "_wait_fim"});
    tick();
    chk({nm, "_pronto"}, int'(pronto), 1);
    chk({nm, "_acertos"}, int'(acertos), ac);
    chk({nm, "_erros"}, int'(erros), er);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_counters"}, int'({acertos, erros}), 0);
    chk({nm, "_pulses"}, int'({jogada_feita, acertou, errou, timeout, pronto}), 0);
    chk({nm, "_estado"}, int'(db_estado), 0);
    chk({nm, "_endereco"}, int'(db_endereco), 0);
    chk({nm, "_jogada_mem"}, int'({db_jogada, db_memoria}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got %0d, expected %0d", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int a;
    logic [3:0] rom [4];
    rom[0] = 4'd1; rom[1] = 4'd2; rom[2] = 4'd4; rom[3] = 4'd8;

    tick(2);
    chk_all_zero("in_reset");
    reset = 1'b0;
    tick(3);
    chk("idle_estado", int'(db_estado), 0);
    chk("idle_pronto", int'(pronto), 0);

    // Round A: all hits.
    f0 = n_feita;
    start_round();
    play(4'd1, 1'b1, 2'd0);
    play(4'd2, 1'b1, 2'd1);
    play(4'd4, 1'b1, 2'd2);
    play(4'd8, 1'b1, 2'd3);
    end_round("roundA", 4, 0);
    chk("roundA_presses", n_feita - f0, 4);
    tick(3);
    chk("fim_holds_pronto", int'(pronto), 1);

    // Round B from FIM: counters cleared, one miss on play 2.
    start_round();
    wait_state(3'd2, "roundB_espera");
    chk("roundB_cleared", int'({acertos, erros, db_endereco, pronto}), 0);
    play(4'd1, 1'b1, 2'd0);
    play(4'd4, 1'b0, 2'd1);
    play(4'd4, 1'b1, 2'd2);
    play(4'd8, 1'b1, 2'd3);
    end_round("roundB", 3, 1);

    // Round C: iniciar held in ESPERA is ignored; multi-button press is an error.
    iniciar = 1'b1;
    tick();
    exp_ac = 0;
    exp_er = 0;
    wait_state(3'd2, "roundC_espera");
    tick(5);
    chk("iniciar_held_estado", int'(db_estado), 2);
    chk("iniciar_held_endereco", int'(db_endereco), 0);
    iniciar = 1'b0;
    play(4'b0011, 1'b0, 2'd0);
    play(4'd2, 1'b1, 2'd1);
    play(4'd4, 1'b1, 2'd2);
    play(4'd8, 1'b1, 2'd3);
    end_round("roundC", 3, 1);

    // Button held across the round start produces no press until re-pressed.
    botoes = 4'd4;
    tick();
    start_round();
    wait_state(3'd2, "held_espera");
    f0 = n_feita;
    tick(8);
    chk("held_no_press_estado", int'(db_estado), 2);
    chk("held_no_press_count", n_feita - f0, 0);
    botoes = 4'd0;
    tick(2);

    // Round D: reset during SOLTA of play 3.
    play(4'd1, 1'b1, 2'd0);
    play(4'd2, 1'b1, 2'd1);
    begin
      exp_t e;
      wait_state(3'd2, "roundD_espera3");
      exp_ac++;
      e = '{ac: 1'b1, er: 1'b0, to: 1'b0, chk_j: 1'b1, jog: 4'd4, addr: 2'd2,
            n_ac: 3'(exp_ac), n_er: 3'(exp_er)};
      sb.push_back(e);
      botoes = 4'd4;
      tick(3);
    end
    chk("roundD_in_solta", int'(db_estado), 4);
    reset = 1'b1;
    #1;
    chk_all_zero("mid_round_reset");
    botoes = 4'd0;
    tick();
    reset = 1'b0;
    tick();

    // Restart after reset: address begins at 0.
    start_round();
    wait_state(3'd2, "restart_espera");
    chk("restart_endereco", int'(db_endereco), 0);
`ifdef PJ_TIMEOUT_EN
    begin
      exp_t e;
      exp_er++;
      e = '{ac: 1'b0, er: 1'b1, to: 1'b1, chk_j: 1'b0, jog: 4'd0, addr: 2'd0,
            n_ac: 3'(exp_ac), n_er: 3'(exp_er)};
      sb.push_back(e);
      tick(9);
      chk("timeout_10th_cycle", int'(timeout), 1);
      tick();
      chk("timeout_to_proxima", int'(db_estado), 5);
      wait_state(3'd2, "timeout_next_espera");
      chk("timeout_addr_advance", int'(db_endereco), 1);
      a = 1;
    end
`else
    tick(30);
    chk("no_timeout_estado", int'(db_estado), 2);
    chk("no_timeout_pulse", int'(timeout), 0);
    a = 0;
`endif
    play(rom[a], 1'b1, 2'(a));
    tick(4);
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
